// File: rtl/mp_reg_file_pkg.sv
// Shared constants and types for the multi-ported register file.
package mp_reg_file_pkg;

    // Default geometry: a 32 x 32-bit integer register file.
    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    // Register index at the default geometry.
    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/mp_reg_file_fwd.sv
// One read port: selects stored data or same-cycle write data, and derives the
// port's busy flag from the scoreboard bit plus any same-cycle write/issue.
module mp_reg_file_fwd
    import mp_reg_file_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic            reset,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] stored_data,
    input  logic            stored_busy,
    input  logic            wr_en   [NWR],
    input  logic [AW-1:0]   wr_addr [NWR],
    input  logic [XLEN-1:0] wr_data [NWR],
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            rd_busy
);

    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic            iss_hit;

    // Priority match: later (higher-index) ports override earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = stored_data;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data[p];
            end
        end
    end

    assign iss_hit = iss_en && (iss_addr == rd_addr);

    // Output select; reset and register 0 force zero over every other path.
    always_comb begin
        rd_data = stored_data;
        rd_busy = stored_busy;
        if ((BYPASS != 0) && fwd_hit && (rd_addr != '0)) begin
            rd_data = fwd_data;
            // A new issue to the same register keeps it busy for that producer.
            if (!iss_hit) begin
                rd_busy = 1'b0;
            end
        end
        if (reset || (rd_addr == '0)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/mp_reg_file.sv
// Multi-ported register file with a per-register busy scoreboard and optional
// write-to-read forwarding. Register 0 is hard-wired to zero and never busy.
module mp_reg_file
    import mp_reg_file_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NRD    = 2,
    parameter  int unsigned NWR    = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rd_addr  [NRD],
    output logic [XLEN-1:0] rd_data  [NRD],
    output logic            rd_busy  [NRD],
    input  logic            wr_en    [NWR],
    input  logic [AW-1:0]   wr_addr  [NWR],
    input  logic [XLEN-1:0] wr_data  [NWR],
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic            any_busy
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next state: writes in ascending port order so the highest port wins;
    // issue is applied after write-clears so a same-cycle issue keeps busy set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w] != '0)) begin
                regs_d[wr_addr[w]] = wr_data[w];
                busy_d[wr_addr[w]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // Storage and scoreboard flops, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        mp_reg_file_fwd #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_fwd (
            .reset       (reset),
            .rd_addr     (rd_addr[i]),
            .stored_data (regs_q[rd_addr[i]]),
            .stored_busy (busy_q[rd_addr[i]]),
            .wr_en       (wr_en),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .iss_en      (iss_en),
            .iss_addr    (iss_addr),
            .rd_data     (rd_data[i]),
            .rd_busy     (rd_busy[i])
        );
    end

    // Stored busy bits only; same-cycle writes do not affect this flag.
    assign any_busy = ~reset & (|busy_q[NREGS-1:1]);

endmodule

// File: tb/tb_mp_reg_file.sv
// Bench for mp_reg_file: a default BYPASS=1 instance and a BYPASS=0 instance
// share stimulus; a 16x64, 4-read, 1-write instance runs its own random traffic.
module tb_mp_reg_file;

    localparam int unsigned NRD = 2;
    localparam int unsigned NWR = 2;
    localparam int unsigned AW  = 5;
    localparam int unsigned NR  = 32;
    localparam int unsigned CRD = 4;
    localparam int unsigned CAW = 4;
    localparam int unsigned CNR = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for instances a and b.
    logic [AW-1:0] rd_addr [NRD];
    logic          wr_en   [NWR];
    logic [AW-1:0] wr_addr [NWR];
    logic [31:0]   wr_data [NWR];
    logic          iss_en;
    logic [AW-1:0] iss_addr;

    logic [31:0] a_rd_data [NRD];
    logic        a_rd_busy [NRD];
    logic        a_any_busy;
    logic [31:0] b_rd_data [NRD];
    logic        b_rd_busy [NRD];
    logic        b_any_busy;

    // Stimulus and outputs for instance c.
    logic [CAW-1:0] c_rd_addr [CRD];
    logic           c_wr_en   [1];
    logic [CAW-1:0] c_wr_addr [1];
    logic [63:0]    c_wr_data [1];
    logic           c_iss_en;
    logic [CAW-1:0] c_iss_addr;
    logic [63:0]    c_rd_data [CRD];
    logic           c_rd_busy [CRD];
    logic           c_any_busy;

    mp_reg_file #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(a_any_busy)
    );

    mp_reg_file #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(b_any_busy)
    );

    mp_reg_file #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .rd_addr(c_rd_addr), .rd_data(c_rd_data),
        .rd_busy(c_rd_busy), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .any_busy(c_any_busy)
    );

    // Reference state.
    logic [31:0]    m_regs [NR];
    logic [NR-1:0]  m_busy;
    logic [63:0]    c_regs [CNR];
    logic [CNR-1:0] c_busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        string       tag;
        int unsigned sel;
        int unsigned port;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] observe(input int unsigned sel, input int unsigned port);
        case (sel)
            0: return 64'(a_rd_data[port[0]]);
            1: return 64'(a_rd_busy[port[0]]);
            2: return 64'(a_any_busy);
            3: return 64'(b_rd_data[port[0]]);
            4: return 64'(b_rd_busy[port[0]]);
            5: return 64'(b_any_busy);
            6: return c_rd_data[port[1:0]];
            7: return 64'(c_rd_busy[port[1:0]]);
            default: return 64'(c_any_busy);
        endcase
    endfunction

    // Forwarding-aware expectation for instance a.
    function automatic logic [31:0] exp_a_data(input int unsigned p);
        logic [AW-1:0] a;
        logic [31:0]   r;
        a = rd_addr[p];
        if (reset || a == '0) return '0;
        r = m_regs[a];
        for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w] == a) r = wr_data[w];
        return r;
    endfunction

    function automatic logic exp_a_busy(input int unsigned p);
        logic [AW-1:0] a;
        logic          hit;
        a   = rd_addr[p];
        hit = 1'b0;
        if (reset || a == '0) return 1'b0;
        for (int w = 0; w < NWR; w++) if (wr_en[w] && wr_addr[w] == a) hit = 1'b1;
        if (hit && !(iss_en && iss_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [63:0] exp_c_data(input int unsigned p);
        logic [CAW-1:0] a;
        a = c_rd_addr[p];
        if (reset || a == '0) return '0;
        if (c_wr_en[0] && c_wr_addr[0] == a) return c_wr_data[0];
        return c_regs[a];
    endfunction

    function automatic logic exp_c_busy(input int unsigned p);
        logic [CAW-1:0] a;
        a = c_rd_addr[p];
        if (reset || a == '0) return 1'b0;
        if (c_wr_en[0] && c_wr_addr[0] == a && !(c_iss_en && c_iss_addr == a)) return 1'b0;
        return c_busy[a];
    endfunction

    task automatic push_all();
        logic any_m;
        any_m = !reset && (|m_busy[NR-1:1]);
        for (int unsigned p = 0; p < NRD; p++) begin
            sb_q.push_back('{$sformatf("a_data%0d", p), 0, p, 64'(exp_a_data(p))});
            sb_q.push_back('{$sformatf("a_busy%0d", p), 1, p, 64'(exp_a_busy(p))});
            sb_q.push_back('{$sformatf("b_data%0d", p), 3, p,
                             reset ? 64'h0 : 64'(m_regs[rd_addr[p]])});
            sb_q.push_back('{$sformatf("b_busy%0d", p), 4, p,
                             reset ? 64'h0 : 64'(m_busy[rd_addr[p]])});
        end
        sb_q.push_back('{"a_any", 2, 0, 64'(any_m)});
        sb_q.push_back('{"b_any", 5, 0, 64'(any_m)});
        for (int unsigned p = 0; p < CRD; p++) begin
            sb_q.push_back('{$sformatf("c_data%0d", p), 6, p, exp_c_data(p)});
            sb_q.push_back('{$sformatf("c_busy%0d", p), 7, p, 64'(exp_c_busy(p))});
        end
        sb_q.push_back('{"c_any", 8, 0, 64'(!reset && (|c_busy[CNR-1:1]))});
    endtask

    // Queue expectations for the inputs just driven, then compare once settled.
    task automatic drive_check();
        exp_t e;
        push_all();
        #3;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel, e.port), e.val);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        for (int r = 0; r < CNR; r++) c_regs[r] = '0;
        m_busy = '0;
        c_busy = '0;
    endtask

    // Advance one clock edge and the reference state with the held inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_clear();
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w] != '0) begin
                    m_regs[wr_addr[w]] = wr_data[w];
                    m_busy[wr_addr[w]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
            if (c_wr_en[0] && c_wr_addr[0] != '0) begin
                c_regs[c_wr_addr[0]] = c_wr_data[0];
                c_busy[c_wr_addr[0]] = 1'b0;
            end
            if (c_iss_en && c_iss_addr != '0) c_busy[c_iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        for (int p = 0; p < NRD; p++) rd_addr[p] = '0;
        for (int w = 0; w < NWR; w++) begin
            wr_en[w] = 1'b0; wr_addr[w] = '0; wr_data[w] = '0;
        end
        iss_en = 1'b0; iss_addr = '0;
        for (int p = 0; p < CRD; p++) c_rd_addr[p] = '0;
        c_wr_en[0] = 1'b0; c_wr_addr[0] = '0; c_wr_data[0] = '0;
        c_iss_en = 1'b0; c_iss_addr = '0;
    endtask

    initial begin
        model_clear();
        idle();
        #1;
        // Active writes/issues/bypass while in reset must all read as zero.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        rd_addr[0] = 5'd5; iss_en = 1'b1; iss_addr = 5'd5;
        c_wr_en[0] = 1'b1; c_wr_addr[0] = 4'd2; c_wr_data[0] = 64'h1;
        c_rd_addr[0] = 4'd2;
        drive_check();
        check_eq("rst_bypass_data", 64'(a_rd_data[0]), 64'h0);
        tick();
        reset = 1'b0;
        idle();
        drive_check();
        check_eq("post_rst_r5", 64'(a_rd_data[0]), 64'h0);
        tick();

        // Write r5, then issue r6, then reset in mid-cycle.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; rd_addr[0] = 5'd5;
        drive_check();
        check_eq("byp_r5", 64'(a_rd_data[0]), 64'hDEADBEEF);
        check_eq("nobyp_r5", 64'(b_rd_data[0]), 64'h0);
        tick();
        idle(); iss_en = 1'b1; iss_addr = 5'd6;
        drive_check();
        tick();
        idle(); rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
        drive_check();
        check_eq("r5_stored", 64'(a_rd_data[0]), 64'hDEADBEEF);
        check_eq("r6_busy", 64'(a_rd_busy[1]), 64'h1);
        reset = 1'b1;
        model_clear();
        drive_check();
        check_eq("midrst_r5", 64'(a_rd_data[0]), 64'h0);
        check_eq("midrst_busy", 64'(a_rd_busy[1]), 64'h0);
        check_eq("midrst_any", 64'(a_any_busy), 64'h0);
        tick();
        reset = 1'b0;

        // Register 0: write on port 1 and issue.
        idle(); wr_en[1] = 1'b1; wr_addr[1] = '0; wr_data[1] = 32'h1234;
        iss_en = 1'b1; iss_addr = '0;
        drive_check();
        tick();
        idle();
        drive_check();
        check_eq("r0_data", 64'(a_rd_data[0]), 64'h0);
        check_eq("r0_busy", 64'(a_rd_busy[0]), 64'h0);
        check_eq("r0_any", 64'(a_any_busy), 64'h0);
        tick();

        // Same-cycle collision on r7: port 1 wins.
        wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'hAAAA;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'h5555; rd_addr[0] = 5'd7;
        drive_check();
        check_eq("coll_byp", 64'(a_rd_data[0]), 64'h5555);
        tick();
        idle(); rd_addr[0] = 5'd7;
        drive_check();
        check_eq("coll_a", 64'(a_rd_data[0]), 64'h5555);
        check_eq("coll_b", 64'(b_rd_data[0]), 64'h5555);
        tick();

        // Bypass vs registered read of r3.
        idle(); wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h11;
        drive_check();
        tick();
        wr_data[0] = 32'h77; rd_addr[1] = 5'd3;
        drive_check();
        check_eq("byp_r3_a", 64'(a_rd_data[1]), 64'h77);
        check_eq("byp_r3_b", 64'(b_rd_data[1]), 64'h11);
        tick();
        idle(); rd_addr[1] = 5'd3;
        drive_check();
        check_eq("r3_b_next", 64'(b_rd_data[1]), 64'h77);
        tick();

        // Scoreboard on r9: issue, clear by write, issue+write keeps it set.
        iss_en = 1'b1; iss_addr = 5'd9;
        drive_check();
        tick();
        idle(); rd_addr[0] = 5'd9;
        drive_check();
        check_eq("r9_busy", 64'(a_rd_busy[0]), 64'h1);
        check_eq("r9_any", 64'(a_any_busy), 64'h1);
        tick();
        wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h9;
        drive_check();
        check_eq("r9_wr_byp_busy", 64'(a_rd_busy[0]), 64'h0);
        check_eq("r9_wr_nobyp_busy", 64'(b_rd_busy[0]), 64'h1);
        check_eq("r9_wr_any", 64'(a_any_busy), 64'h1);
        tick();
        idle(); rd_addr[0] = 5'd9;
        drive_check();
        check_eq("r9_cleared", 64'(a_rd_busy[0]), 64'h0);
        tick();
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
        drive_check();
        tick();
        idle(); rd_addr[0] = 5'd9;
        drive_check();
        check_eq("r9_set_wins", 64'(a_rd_busy[0]), 64'h1);
        check_eq("r9_set_any", 64'(a_any_busy), 64'h1);
        tick();

        // Random traffic on all three instances against the reference model.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int p = 0; p < NRD; p++) rd_addr[p] = 5'($urandom_range(0, 7));
            for (int w = 0; w < NWR; w++) begin
                wr_en[w]   = ($urandom_range(0, 2) != 0);
                wr_addr[w] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                          : 5'($urandom_range(0, 31));
                wr_data[w] = $urandom;
            end
            iss_en   = ($urandom_range(0, 1) == 1);
            iss_addr = 5'($urandom_range(0, 7));
            for (int p = 0; p < CRD; p++) c_rd_addr[p] = 4'($urandom_range(0, 15));
            c_wr_en[0]   = ($urandom_range(0, 2) != 0);
            c_wr_addr[0] = 4'($urandom_range(0, 15));
            c_wr_data[0] = {$urandom, $urandom};
            c_iss_en     = ($urandom_range(0, 1) == 1);
            c_iss_addr   = 4'($urandom_range(0, 15));
            drive_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_reg_file.md
MP_REG_FILE -- requirements
Module: mp_reg_file

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, at least 2.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 gives plain registered reads.
REQ-006 Derived constant AW = clog2(NREGS).
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 rd_addr[NRD]  in  AW each  read-port register addresses.
REQ-010 rd_data[NRD]  out  XLEN each  read-port data.
REQ-011 rd_busy[NRD]  out  1 each  read-port register has a pending producer.
REQ-012 wr_en[NWR]  in  1 each  write-port enables.
REQ-013 wr_addr[NWR]  in  AW each  write-port register addresses.
REQ-014 wr_data[NWR]  in  XLEN each  write-port data.
REQ-015 iss_en  in  1  issue strobe; marks register iss_addr busy.
REQ-016 iss_addr  in  AW  destination register of the issued instruction.
REQ-017 any_busy  out  1  OR of all scoreboard bits.

Function
REQ-018 Register 0 SHALL read as 0 on every port, ignore all writes, and never become busy.
REQ-019 Reads SHALL be combinational from rd_addr, with zero-cycle latency.
REQ-020 Each write SHALL update its register on the clk edge where wr_en=1 and wr_addr!=0.
REQ-021 When several enabled write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-022 With BYPASS=1, a read whose address matches an enabled same-cycle write (addr!=0) SHALL return that wr_data, using highest-index-port priority.
REQ-023 With BYPASS=0, a read SHALL return the stored value; new data SHALL become visible the cycle after the write.
REQ-024 Scoreboard: iss_en=1 with iss_addr!=0 SHALL set busy[iss_addr] at the next edge.
REQ-025 Scoreboard: any enabled write to address A (A!=0) SHALL clear busy[A] at the next edge.
REQ-026 If an issue and a write hit the same register in the same cycle, set SHALL win, so busy stays 1 for the new producer.
REQ-027 rd_busy SHALL equal the stored busy bit.
REQ-028 With BYPASS=1, rd_busy SHALL read 0 when a same-cycle write matches the read address and no same-cycle issue targets it.
REQ-029 any_busy SHALL be the registered OR of busy[1..NREGS-1], with no bypass.
REQ-030 Out-of-range addresses are impossible because NREGS is a power of two, so no range check is needed.

Reset
REQ-031 reset=1 SHALL asynchronously clear all registers and all busy bits to 0.
REQ-032 During reset, rd_data SHALL be 0, rd_busy 0 and any_busy 0, regardless of inputs, including bypass paths.
REQ-033 Writes and issues presented while reset=1 SHALL be discarded; operation resumes at the first edge after deassertion.

Structure
REQ-034 Package mp_reg_file_pkg SHALL hold the default XLEN/NREGS constants and a reg_addr_t typedef.
REQ-035 Sub-module mp_reg_file_fwd SHALL implement one read port's priority bypass mux; it is instantiated NRD times.
REQ-036 Storage and scoreboard SHALL be flop arrays in the top module; no latches, and no memory macro is required.

Verification
REQ-037 Reset scenario: write 0xDEADBEEF to r5, assert reset mid-cycle -> r5 reads 0 immediately and busy is 0.
REQ-038 Register 0 scenario: write 0x1234 to r0 on port 1 and issue r0 -> rd_data=0, rd_busy=0 and any_busy=0 on the following cycle.
REQ-039 Write collision: port0 writes r7=0xAAAA and port1 writes r7=0x5555 in the same cycle -> r7 reads 0x5555 next cycle.
REQ-040 Bypass (BYPASS=1): same-cycle write r3=0x77 while reading r3 -> rd_data=0x77 that cycle; with BYPASS=0 -> old value, then 0x77 next cycle.
REQ-041 Scoreboard: issue r9 -> rd_busy=1 and any_busy=1 next cycle; write r9 -> busy clears; simultaneous issue and write of r9 -> busy stays 1.
REQ-042 Parameter sweep: NREGS=16, NRD=4, NWR=1, XLEN=64 -> random writes and reads match a reference model over 10k cycles.
